decode_stage: RTL and testbench

// Pipelined, handshaked RV32I/RV32E decode stage between fetch and execute.
// - Decodes instr_i and drives RF read selects.
// - Resolves branches and jumps from same-cycle RF data.
// - Registers a control bundle for execute.
// - Adds full B/H/W load/store decode, illegal-instruction flagging and back-pressure buffering.

---
 rtl/decode_pkg.sv | 76 +++++++
 rtl/decode_logic.sv | 189 ++++++++++++++++++
 rtl/decode_stage.sv | 105 ++++++++++
 tb/tb_decode_stage.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared types and encodings for the RV32I/RV32E decode stage: control bundle,
// opcode/funct3 constants, write-back and memory-size encodings, ALU op codes.
package decode_pkg;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  localparam logic [2:0] F3_SB   = 3'b000;
  localparam logic [2:0] F3_SH   = 3'b001;
  localparam logic [2:0] F3_SW   = 3'b010;

  // ALU op codes line up with the OP/OP-IMM funct3 field
  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SLL  = 3'b001;
  localparam logic [2:0] ALU_SLT  = 3'b010;
  localparam logic [2:0] ALU_SLTU = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_SR   = 3'b101;
  localparam logic [2:0] ALU_OR   = 3'b110;
  localparam logic [2:0] ALU_AND  = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_src_e;

  typedef enum logic [1:0] {
    MEM_B = 2'd0,
    MEM_H = 2'd1,
    MEM_W = 2'd2
  } mem_size_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        rd_we;
    wb_src_e     wb_src;
    logic [2:0]  alu_op;
    logic        alu_qual;
    logic        in1_sel;
    logic        in2_sel;
    logic [31:0] imm;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        mem_re;
    logic        mem_we;
    logic [3:0]  mem_be;
    mem_size_e   mem_size;
    logic        mem_unsigned;
    logic        illegal;
  } decode_ctrl_t;

  function automatic logic regOutOfRange(input logic [4:0] idx, input int numRegs);
    return (numRegs < 32) && ({27'd0, idx} >= 32'(numRegs));
  endfunction

endpackage

// File: rtl/decode_logic.sv
// Pure combinational decoder: instruction word plus same-cycle register data in,
// control bundle, register selects and branch/jump resolution out.
module decode_logic
  import decode_pkg::*;
#(
  parameter int NUM_REGS = 32
) (
  input  logic [31:0]  pc_i,
  input  logic [31:0]  instr_i,
  input  logic [31:0]  rs1_data_i,
  input  logic [31:0]  rs2_data_i,
  output logic [4:0]   rs1_sel_o,
  output logic [4:0]   rs2_sel_o,
  output decode_ctrl_t ctrl_o,
  output logic         taken_o,
  output logic [31:0]  target_o
);

  logic [6:0]  w_opcode;
  logic [4:0]  w_rd;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  logic [31:0] w_immI;
  logic [31:0] w_immS;
  logic [31:0] w_immB;
  logic [31:0] w_immU;
  logic [31:0] w_immJ;

  assign w_opcode = instr_i[6:0];
  assign w_rd     = instr_i[11:7];
  assign w_funct3 = instr_i[14:12];
  assign w_rs1    = instr_i[19:15];
  assign w_rs2    = instr_i[24:20];
  assign w_funct7 = instr_i[31:25];
  assign w_immI   = {{20{instr_i[31]}}, instr_i[31:20]};
  assign w_immS   = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign w_immB   = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign w_immU   = {instr_i[31:12], 12'd0};
  assign w_immJ   = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

  logic w_useRd;
  logic w_useRs1;
  logic w_useRs2;
  logic w_isBranch;
  logic w_isJump;
  logic w_illegal;
  logic w_brCond;

  always_comb begin
    ctrl_o        = '0;
    ctrl_o.pc     = pc_i;
    ctrl_o.op1    = rs1_data_i;
    ctrl_o.op2    = rs2_data_i;
    ctrl_o.wb_src = WB_ALU;
    ctrl_o.mem_size = MEM_B;
    w_useRd    = 1'b0;
    w_useRs1   = 1'b0;
    w_useRs2   = 1'b0;
    w_isBranch = 1'b0;
    w_isJump   = 1'b0;
    w_illegal  = 1'b0;
    target_o   = '0;

    case (w_opcode)
      OPC_OP_IMM: begin
        w_useRd = 1'b1;
        w_useRs1 = 1'b1;
        ctrl_o.in2_sel = 1'b1;
        ctrl_o.imm = w_immI;
        ctrl_o.alu_op = w_funct3;
        // Only the shifts carry funct7; SRAI is the sole alternate encoding
        if (w_funct3 == ALU_SLL) begin
          w_illegal = (w_funct7 != F7_BASE);
        end else if (w_funct3 == ALU_SR) begin
          ctrl_o.alu_qual = instr_i[30];
          w_illegal = (w_funct7 != F7_BASE) && (w_funct7 != F7_ALT);
        end
      end
      OPC_OP: begin
        w_useRd = 1'b1;
        w_useRs1 = 1'b1;
        w_useRs2 = 1'b1;
        ctrl_o.alu_op = w_funct3;
        ctrl_o.alu_qual = instr_i[30];
        w_illegal = !((w_funct7 == F7_BASE) ||
                      ((w_funct7 == F7_ALT) && ((w_funct3 == ALU_ADD) || (w_funct3 == ALU_SR))));
      end
      OPC_LUI: begin
        w_useRd = 1'b1;
        ctrl_o.op1 = '0;
        ctrl_o.in2_sel = 1'b1;
        ctrl_o.imm = w_immU;
      end
      OPC_AUIPC: begin
        w_useRd = 1'b1;
        ctrl_o.in1_sel = 1'b1;
        ctrl_o.in2_sel = 1'b1;
        ctrl_o.imm = w_immU;
      end
      OPC_LOAD: begin
        w_useRd = 1'b1;
        w_useRs1 = 1'b1;
        ctrl_o.mem_re = 1'b1;
        ctrl_o.wb_src = WB_MEM;
        ctrl_o.in2_sel = 1'b1;
        ctrl_o.imm = w_immI;
        ctrl_o.mem_unsigned = w_funct3[2];
        if ((w_funct3 == 3'b011) || (w_funct3 == 3'b110) || (w_funct3 == 3'b111))
          w_illegal = 1'b1;
        else
          ctrl_o.mem_size = mem_size_e'(w_funct3[1:0]);
      end
      OPC_STORE: begin
        w_useRs1 = 1'b1;
        w_useRs2 = 1'b1;
        ctrl_o.mem_we = 1'b1;
        ctrl_o.in2_sel = 1'b1;
        ctrl_o.imm = w_immS;
        case (w_funct3)
          F3_SB: begin ctrl_o.mem_be = 4'b0001; ctrl_o.mem_size = MEM_B; end
          F3_SH: begin ctrl_o.mem_be = 4'b0011; ctrl_o.mem_size = MEM_H; end
          F3_SW: begin ctrl_o.mem_be = 4'b1111; ctrl_o.mem_size = MEM_W; end
          default: w_illegal = 1'b1;
        endcase
      end
      OPC_BRANCH: begin
        w_useRs1 = 1'b1;
        w_useRs2 = 1'b1;
        w_isBranch = 1'b1;
        ctrl_o.imm = w_immB;
        target_o = pc_i + w_immB;
        w_illegal = (w_funct3 == 3'b010) || (w_funct3 == 3'b011);
      end
      OPC_JAL: begin
        w_useRd = 1'b1;
        w_isJump = 1'b1;
        ctrl_o.wb_src = WB_PC4;
        ctrl_o.in1_sel = 1'b1;
        ctrl_o.in2_sel = 1'b1;
        ctrl_o.imm = w_immJ;
        target_o = pc_i + w_immJ;
      end
      OPC_JALR: begin
        w_useRd = 1'b1;
        w_useRs1 = 1'b1;
        w_isJump = 1'b1;
        ctrl_o.wb_src = WB_PC4;
        ctrl_o.in2_sel = 1'b1;
        ctrl_o.imm = w_immI;
        target_o = (rs1_data_i + w_immI) & ~32'd1;
        w_illegal = (w_funct3 != 3'b000);
      end
      OPC_MISC_MEM: begin
      end
      default: w_illegal = 1'b1;
    endcase

    // RV32E: any referenced register beyond the implemented file traps
    if ((w_useRd && regOutOfRange(w_rd, NUM_REGS)) ||
        (w_useRs1 && regOutOfRange(w_rs1, NUM_REGS)) ||
        (w_useRs2 && regOutOfRange(w_rs2, NUM_REGS)))
      w_illegal = 1'b1;

    rs1_sel_o      = w_useRs1 ? w_rs1 : 5'd0;
    rs2_sel_o      = w_useRs2 ? w_rs2 : 5'd0;
    ctrl_o.rd      = w_useRd ? w_rd : 5'd0;
    ctrl_o.rd_we   = w_useRd && (w_rd != 5'd0) && !w_illegal;
    ctrl_o.mem_re  = ctrl_o.mem_re && !w_illegal;
    ctrl_o.mem_we  = ctrl_o.mem_we && !w_illegal;
    ctrl_o.illegal = w_illegal;
  end

  always_comb begin
    case (w_funct3)
      F3_BEQ:  w_brCond = (rs1_data_i == rs2_data_i);
      F3_BNE:  w_brCond = (rs1_data_i != rs2_data_i);
      F3_BLT:  w_brCond = ($signed(rs1_data_i) < $signed(rs2_data_i));
      F3_BGE:  w_brCond = !($signed(rs1_data_i) < $signed(rs2_data_i));
      F3_BLTU: w_brCond = (rs1_data_i < rs2_data_i);
      F3_BGEU: w_brCond = !(rs1_data_i < rs2_data_i);
      default: w_brCond = 1'b0;
    endcase
  end

  assign taken_o = !w_illegal && (w_isJump || (w_isBranch && w_brCond));

endmodule

// File: rtl/decode_stage.sv
// Handshaked decode stage: decoder, main/skid output registers and the
// registered redirect pulse for taken branches and jumps.
module decode_stage
  import decode_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter bit SKID_EN  = 1'b1
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         flush_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [31:0]  pc_i,
  input  logic [31:0]  instr_i,
  output logic [4:0]   rs1_sel_o,
  output logic [4:0]   rs2_sel_o,
  input  logic [31:0]  rs1_data_i,
  input  logic [31:0]  rs2_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output decode_ctrl_t ctrl_o,
  output logic         redirect_o,
  output logic [31:0]  redirect_pc_o
);

  decode_ctrl_t w_ctrl;
  logic         w_taken;
  logic [31:0]  w_target;

  decode_logic #(.NUM_REGS(NUM_REGS)) u_decode (
    .pc_i       (pc_i),
    .instr_i    (instr_i),
    .rs1_data_i (rs1_data_i),
    .rs2_data_i (rs2_data_i),
    .rs1_sel_o  (rs1_sel_o),
    .rs2_sel_o  (rs2_sel_o),
    .ctrl_o     (w_ctrl),
    .taken_o    (w_taken),
    .target_o   (w_target)
  );

  decode_ctrl_t r_main;
  decode_ctrl_t r_skid;
  logic         r_mainValid;
  logic         r_skidValid;
  logic         r_redirect;
  logic [31:0]  r_redirectPc;
  logic         w_inReady;
  logic         w_accept;
  logic         w_pop;

  // The redirect cycle blocks input so the wrong-path fetch is never taken
  always_comb begin
    if (SKID_EN)
      w_inReady = !r_skidValid;
    else
      w_inReady = !r_mainValid || out_ready_i;
    w_inReady = w_inReady && !r_redirect && !reset_i;
  end

  assign w_accept = in_valid_i && w_inReady && !flush_i;
  assign w_pop    = r_mainValid && out_ready_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_main       <= '0;
      r_skid       <= '0;
      r_mainValid  <= 1'b0;
      r_skidValid  <= 1'b0;
      r_redirect   <= 1'b0;
      r_redirectPc <= '0;
    end else if (flush_i) begin
      r_mainValid <= 1'b0;
      r_skidValid <= 1'b0;
      r_redirect  <= 1'b0;
    end else begin
      r_redirect <= w_accept && w_taken;
      if (w_accept && w_taken)
        r_redirectPc <= w_target;
      // Skid drains before new input so program order is preserved
      if (!r_mainValid || w_pop) begin
        if (SKID_EN && r_skidValid) begin
          r_main      <= r_skid;
          r_mainValid <= 1'b1;
          r_skidValid <= 1'b0;
        end else begin
          r_mainValid <= w_accept;
          if (w_accept)
            r_main <= w_ctrl;
        end
      end else if (SKID_EN && w_accept) begin
        r_skid      <= w_ctrl;
        r_skidValid <= 1'b1;
      end
    end
  end

  assign in_ready_o    = w_inReady;
  assign out_valid_o   = r_mainValid;
  assign ctrl_o        = r_main;
  assign redirect_o    = r_redirect;
  assign redirect_pc_o = r_redirectPc;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage (RV32E build with skid buffer): decode fields,
// branch/jump redirect, loads/stores, back-pressure, illegal flags, flush and reset.
module tb_decode_stage;
  import decode_pkg::*;

  logic         clk;
  logic         resetI;
  logic         flushI;
  logic         inValid;
  logic         inReady;
  logic [31:0]  pcIn;
  logic [31:0]  instrIn;
  logic [4:0]   rs1Sel;
  logic [4:0]   rs2Sel;
  logic [31:0]  rs1Data;
  logic [31:0]  rs2Data;
  logic         outValid;
  logic         outReady;
  decode_ctrl_t ctrl;
  logic         redirect;
  logic [31:0]  redirectPc;
  logic [31:0]  rf [32];
  int           nChecks;
  int           nFails;

  decode_stage #(.NUM_REGS(16), .SKID_EN(1'b1)) dut (
    .clk_i         (clk),
    .reset_i       (resetI),
    .flush_i       (flushI),
    .in_valid_i    (inValid),
    .in_ready_o    (inReady),
    .pc_i          (pcIn),
    .instr_i       (instrIn),
    .rs1_sel_o     (rs1Sel),
    .rs2_sel_o     (rs2Sel),
    .rs1_data_i    (rs1Data),
    .rs2_data_i    (rs2Data),
    .out_valid_o   (outValid),
    .out_ready_i   (outReady),
    .ctrl_o        (ctrl),
    .redirect_o    (redirect),
    .redirect_pc_o (redirectPc)
  );

  assign rs1Data = rf[rs1Sel];
  assign rs2Data = rf[rs2Sel];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] pc, input logic [31:0] instr);
    pcIn = pc;
    instrIn = instr;
    inValid = 1'b1;
    tick();
    inValid = 1'b0;
  endtask

  task automatic test_reset();
    resetI = 1'b1;
    tick();
    nChecks++; if (outValid !== 1'b0) begin nFails++; $display("[TB] FAIL rst_valid: got %0h want 0", outValid); end
    nChecks++; if (redirect !== 1'b0) begin nFails++; $display("[TB] FAIL rst_redirect: got %0h want 0", redirect); end
    nChecks++; if (redirectPc !== 32'd0) begin nFails++; $display("[TB] FAIL rst_redirect_pc: got %0h want 0", redirectPc); end
    nChecks++; if (ctrl !== '0) begin nFails++; $display("[TB] FAIL rst_ctrl: got %0h want 0", ctrl); end
    nChecks++; if (inReady !== 1'b0) begin nFails++; $display("[TB] FAIL rst_in_ready: got %0h want 0", inReady); end
    resetI = 1'b0;
    #1;
    nChecks++; if (inReady !== 1'b1) begin nFails++; $display("[TB] FAIL post_rst_in_ready: got %0h want 1", inReady); end
  endtask

  task automatic test_alu();
    outReady = 1'b1;
    issue(32'h0, 32'hFFF00293);
    nChecks++; if (outValid !== 1'b1) begin nFails++; $display("[TB] FAIL addi_valid: got %0h want 1", outValid); end
    nChecks++; if (ctrl.rd !== 5'd5) begin nFails++; $display("[TB] FAIL addi_rd: got %0h want 5", ctrl.rd); end
    nChecks++; if (ctrl.rd_we !== 1'b1) begin nFails++; $display("[TB] FAIL addi_rd_we: got %0h want 1", ctrl.rd_we); end
    nChecks++; if (ctrl.imm !== 32'hFFFFFFFF) begin nFails++; $display("[TB] FAIL addi_imm: got %0h want ffffffff", ctrl.imm); end
    nChecks++; if (ctrl.alu_op !== 3'b000) begin nFails++; $display("[TB] FAIL addi_alu_op: got %0h want 0", ctrl.alu_op); end
    nChecks++; if (ctrl.in2_sel !== 1'b1) begin nFails++; $display("[TB] FAIL addi_in2_sel: got %0h want 1", ctrl.in2_sel); end
    tick();
    nChecks++; if (outValid !== 1'b0) begin nFails++; $display("[TB] FAIL addi_drained: got %0h want 0", outValid); end

    rf[1] = 32'd10;
    rf[2] = 32'd3;
    pcIn = 32'h4;
    instrIn = 32'h402081B3;
    inValid = 1'b1;
    #1;
    nChecks++; if (rs1Sel !== 5'd1) begin nFails++; $display("[TB] FAIL sub_rs1_sel: got %0h want 1", rs1Sel); end
    nChecks++; if (rs2Sel !== 5'd2) begin nFails++; $display("[TB] FAIL sub_rs2_sel: got %0h want 2", rs2Sel); end
    tick();
    inValid = 1'b0;
    nChecks++; if (ctrl.alu_qual !== 1'b1) begin nFails++; $display("[TB] FAIL sub_alu_qual: got %0h want 1", ctrl.alu_qual); end
    nChecks++; if (ctrl.op1 !== 32'd10) begin nFails++; $display("[TB] FAIL sub_op1: got %0h want a", ctrl.op1); end
    nChecks++; if (ctrl.op2 !== 32'd3) begin nFails++; $display("[TB] FAIL sub_op2: got %0h want 3", ctrl.op2); end
    nChecks++; if (ctrl.in2_sel !== 1'b0) begin nFails++; $display("[TB] FAIL sub_in2_sel: got %0h want 0", ctrl.in2_sel); end

    issue(32'h8, 32'h123453B7);
    nChecks++; if (ctrl.imm !== 32'h12345000) begin nFails++; $display("[TB] FAIL lui_imm: got %0h want 12345000", ctrl.imm); end
    nChecks++; if (ctrl.op1 !== 32'd0) begin nFails++; $display("[TB] FAIL lui_op1: got %0h want 0", ctrl.op1); end
    nChecks++; if (ctrl.rd !== 5'd7) begin nFails++; $display("[TB] FAIL lui_rd: got %0h want 7", ctrl.rd); end
    tick();
  endtask

  task automatic test_branch();
    rf[1] = 32'd7;
    rf[2] = 32'd7;
    issue(32'h100, 32'h00208863);
    nChecks++; if (redirect !== 1'b1) begin nFails++; $display("[TB] FAIL beq_taken_redirect: got %0h want 1", redirect); end
    nChecks++; if (redirectPc !== 32'h110) begin nFails++; $display("[TB] FAIL beq_target: got %0h want 110", redirectPc); end
    nChecks++; if (inReady !== 1'b0) begin nFails++; $display("[TB] FAIL beq_in_ready: got %0h want 0", inReady); end
    tick();
    nChecks++; if (redirect !== 1'b0) begin nFails++; $display("[TB] FAIL beq_pulse_len: got %0h want 0", redirect); end
    nChecks++; if (inReady !== 1'b1) begin nFails++; $display("[TB] FAIL beq_ready_back: got %0h want 1", inReady); end

    rf[2] = 32'd8;
    issue(32'h100, 32'h00208863);
    nChecks++; if (redirect !== 1'b0) begin nFails++; $display("[TB] FAIL beq_not_taken: got %0h want 0", redirect); end
    nChecks++; if (outValid !== 1'b1) begin nFails++; $display("[TB] FAIL beq_nt_valid: got %0h want 1", outValid); end
    tick();

    issue(32'h200, 32'h008000EF);
    nChecks++; if (redirectPc !== 32'h208) begin nFails++; $display("[TB] FAIL jal_target: got %0h want 208", redirectPc); end
    nChecks++; if (ctrl.wb_src !== WB_PC4) begin nFails++; $display("[TB] FAIL jal_wb_src: got %0h want 2", ctrl.wb_src); end
    nChecks++; if (ctrl.rd_we !== 1'b1) begin nFails++; $display("[TB] FAIL jal_rd_we: got %0h want 1", ctrl.rd_we); end
    tick();

    rf[1] = 32'h1000;
    issue(32'h300, 32'h00508067);
    nChecks++; if (redirect !== 1'b1) begin nFails++; $display("[TB] FAIL jalr_redirect: got %0h want 1", redirect); end
    nChecks++; if (redirectPc !== 32'h1004) begin nFails++; $display("[TB] FAIL jalr_target: got %0h want 1004", redirectPc); end
    nChecks++; if (ctrl.rd_we !== 1'b0) begin nFails++; $display("[TB] FAIL jalr_x0_rd_we: got %0h want 0", ctrl.rd_we); end
    tick();
  endtask

  task automatic test_mem();
    issue(32'h400, 32'h00321123);
    nChecks++; if (ctrl.mem_we !== 1'b1) begin nFails++; $display("[TB] FAIL sh_mem_we: got %0h want 1", ctrl.mem_we); end
    nChecks++; if (ctrl.mem_be !== 4'b0011) begin nFails++; $display("[TB] FAIL sh_mem_be: got %0h want 3", ctrl.mem_be); end
    nChecks++; if (ctrl.mem_size !== MEM_H) begin nFails++; $display("[TB] FAIL sh_mem_size: got %0h want 1", ctrl.mem_size); end
    nChecks++; if (ctrl.imm !== 32'd2) begin nFails++; $display("[TB] FAIL sh_imm: got %0h want 2", ctrl.imm); end
    nChecks++; if (ctrl.rd_we !== 1'b0) begin nFails++; $display("[TB] FAIL sh_rd_we: got %0h want 0", ctrl.rd_we); end

    issue(32'h404, 32'h0000C283);
    nChecks++; if (ctrl.mem_re !== 1'b1) begin nFails++; $display("[TB] FAIL lbu_mem_re: got %0h want 1", ctrl.mem_re); end
    nChecks++; if (ctrl.mem_size !== MEM_B) begin nFails++; $display("[TB] FAIL lbu_mem_size: got %0h want 0", ctrl.mem_size); end
    nChecks++; if (ctrl.mem_unsigned !== 1'b1) begin nFails++; $display("[TB] FAIL lbu_unsigned: got %0h want 1", ctrl.mem_unsigned); end
    nChecks++; if (ctrl.wb_src !== WB_MEM) begin nFails++; $display("[TB] FAIL lbu_wb_src: got %0h want 1", ctrl.wb_src); end

    issue(32'h408, 32'h00412003);
    nChecks++; if (ctrl.rd_we !== 1'b0) begin nFails++; $display("[TB] FAIL lw_x0_rd_we: got %0h want 0", ctrl.rd_we); end
    nChecks++; if (ctrl.mem_size !== MEM_W) begin nFails++; $display("[TB] FAIL lw_mem_size: got %0h want 2", ctrl.mem_size); end
    nChecks++; if (ctrl.mem_re !== 1'b1) begin nFails++; $display("[TB] FAIL lw_mem_re: got %0h want 1", ctrl.mem_re); end
    tick();
  endtask

  task automatic test_back_to_back();
    outReady = 1'b0;
    issue(32'h500, 32'h00100093);
    pcIn = 32'h504;
    instrIn = 32'h00200113;
    inValid = 1'b1;
    #1;
    nChecks++; if (inReady !== 1'b1) begin nFails++; $display("[TB] FAIL skid_ready_2nd: got %0h want 1", inReady); end
    tick();
    inValid = 1'b0;
    nChecks++; if (inReady !== 1'b0) begin nFails++; $display("[TB] FAIL skid_full_ready: got %0h want 0", inReady); end
    nChecks++; if (ctrl.imm !== 32'd1) begin nFails++; $display("[TB] FAIL stall_hold_a: got %0h want 1", ctrl.imm); end
    tick();
    tick();
    nChecks++; if ((ctrl.rd !== 5'd1) || (ctrl.pc !== 32'h500)) begin nFails++; $display("[TB] FAIL stall_stable: got rd %0h pc %0h want 1 500", ctrl.rd, ctrl.pc); end
    outReady = 1'b1;
    tick();
    nChecks++; if ((outValid !== 1'b1) || (ctrl.rd !== 5'd2) || (ctrl.imm !== 32'd2)) begin nFails++; $display("[TB] FAIL order_second: got v %0h rd %0h want 1 2", outValid, ctrl.rd); end
    nChecks++; if (inReady !== 1'b1) begin nFails++; $display("[TB] FAIL skid_drained_ready: got %0h want 1", inReady); end
    tick();
    nChecks++; if (outValid !== 1'b0) begin nFails++; $display("[TB] FAIL b2b_empty: got %0h want 0", outValid); end
  endtask

  task automatic test_illegal();
    issue(32'h600, 32'h002088B3);
    nChecks++; if (ctrl.illegal !== 1'b1) begin nFails++; $display("[TB] FAIL add_x17_illegal: got %0h want 1", ctrl.illegal); end
    nChecks++; if (ctrl.rd_we !== 1'b0) begin nFails++; $display("[TB] FAIL add_x17_rd_we: got %0h want 0", ctrl.rd_we); end
    issue(32'h604, 32'h0000007F);
    nChecks++; if (ctrl.illegal !== 1'b1) begin nFails++; $display("[TB] FAIL opc7f_illegal: got %0h want 1", ctrl.illegal); end
    issue(32'h608, 32'h0FF0000F);
    nChecks++; if ({ctrl.illegal, ctrl.rd_we, ctrl.mem_re, ctrl.mem_we} !== 4'b0000) begin nFails++; $display("[TB] FAIL fence_nop: got %0h want 0", {ctrl.illegal, ctrl.rd_we, ctrl.mem_re, ctrl.mem_we}); end
    issue(32'h60C, 32'h0000B283);
    nChecks++; if ({ctrl.illegal, ctrl.mem_re} !== 2'b10) begin nFails++; $display("[TB] FAIL ld_f3_011: got %0h want 2", {ctrl.illegal, ctrl.mem_re}); end
    issue(32'h610, 32'h00000073);
    nChecks++; if (ctrl.illegal !== 1'b1) begin nFails++; $display("[TB] FAIL ecall_illegal: got %0h want 1", ctrl.illegal); end
    issue(32'h614, 32'h00080093);
    nChecks++; if (ctrl.illegal !== 1'b1) begin nFails++; $display("[TB] FAIL rs1_x16_illegal: got %0h want 1", ctrl.illegal); end
    issue(32'h618, 32'h00078093);
    nChecks++; if (ctrl.illegal !== 1'b0) begin nFails++; $display("[TB] FAIL rs1_x15_legal: got %0h want 0", ctrl.illegal); end
    issue(32'h61C, 32'h008008EF);
    nChecks++; if ({ctrl.illegal, redirect, ctrl.rd_we} !== 3'b100) begin nFails++; $display("[TB] FAIL jal_x17_no_redirect: got %0h want 4", {ctrl.illegal, redirect, ctrl.rd_we}); end
    tick();
  endtask

  task automatic test_flush();
    outReady = 1'b0;
    issue(32'h700, 32'h00100093);
    issue(32'h704, 32'h00200113);
    pcIn = 32'h708;
    instrIn = 32'h008000EF;
    inValid = 1'b1;
    flushI = 1'b1;
    tick();
    flushI = 1'b0;
    inValid = 1'b0;
    nChecks++; if (outValid !== 1'b0) begin nFails++; $display("[TB] FAIL flush_full_valid: got %0h want 0", outValid); end
    nChecks++; if (redirect !== 1'b0) begin nFails++; $display("[TB] FAIL flush_full_redirect: got %0h want 0", redirect); end
    nChecks++; if (inReady !== 1'b1) begin nFails++; $display("[TB] FAIL flush_skid_cleared: got %0h want 1", inReady); end

    issue(32'h710, 32'h00100093);
    pcIn = 32'h714;
    instrIn = 32'h008000EF;
    inValid = 1'b1;
    flushI = 1'b1;
    tick();
    flushI = 1'b0;
    inValid = 1'b0;
    nChecks++; if ({outValid, redirect} !== 2'b00) begin nFails++; $display("[TB] FAIL flush_jal_ignored: got %0h want 0", {outValid, redirect}); end
    outReady = 1'b1;
    tick();
    nChecks++; if (outValid !== 1'b0) begin nFails++; $display("[TB] FAIL flush_stays_empty: got %0h want 0", outValid); end
  endtask

  task automatic test_reset_mid_stall();
    outReady = 1'b0;
    issue(32'h200, 32'h008000EF);
    tick();
    issue(32'h204, 32'h00200113);
    resetI = 1'b1;
    tick();
    nChecks++; if ({outValid, redirect} !== 2'b00) begin nFails++; $display("[TB] FAIL midrst_valid: got %0h want 0", {outValid, redirect}); end
    nChecks++; if (redirectPc !== 32'd0) begin nFails++; $display("[TB] FAIL midrst_redirect_pc: got %0h want 0", redirectPc); end
    nChecks++; if (ctrl !== '0) begin nFails++; $display("[TB] FAIL midrst_ctrl: got %0h want 0", ctrl); end
    nChecks++; if (inReady !== 1'b0) begin nFails++; $display("[TB] FAIL midrst_in_ready: got %0h want 0", inReady); end
    resetI = 1'b0;
    #1;
    nChecks++; if (inReady !== 1'b1) begin nFails++; $display("[TB] FAIL midrst_ready_after: got %0h want 1", inReady); end
    outReady = 1'b1;
    tick();
    nChecks++; if (outValid !== 1'b0) begin nFails++; $display("[TB] FAIL midrst_dropped: got %0h want 0", outValid); end
  endtask

  initial begin
    nChecks = 0;
    nFails = 0;
    resetI = 1'b1;
    flushI = 1'b0;
    inValid = 1'b0;
    outReady = 1'b0;
    pcIn = '0;
    instrIn = '0;
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    test_reset();
    test_alu();
    test_branch();
    test_mem();
    test_back_to_back();
    test_illegal();
    test_flush();
    test_reset_mid_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nChecks, nFails);
    $finish;
  end

endmodule
